// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw active-low buttons in, conditioned levels and pulses out.
interface key_conditioner_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                any_press;

  // Board/bench side: drives the raw buttons, observes the conditioned outputs.
  modport master (
    output KEY,
    input  key_level,
    input  key_press,
    input  key_release,
    input  any_press
  );

  // Conditioner side: samples the raw buttons, produces the conditioned outputs.
  modport slave (
    input  KEY,
    output key_level,
    output key_press,
    output key_release,
    output any_press
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button front-end: per-key 2-flop synchronizer, saturating debounce
// counter and registered press/release edge pulses. Keys are independent.
module key_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  key_conditioner_if.slave keys
);

  // Terminal count: a mismatch seen at this count is the acceptance sample.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] pressed_in;

  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q,   level_d;
  logic [NUM_KEYS-1:0] press_q,   press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic                any_q,     any_d;

  // Two-flop synchronizer; resets to "released" so a held key is re-qualified after reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= keys.KEY;
      sync2_q <= sync1_q;
    end
  end

  // Buttons are active-low; only the second synchronizer stage is used downstream.
  assign pressed_in = ~sync2_q;

  // Debounce: count consecutive mismatches, toggle the level and emit one pulse on acceptance.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      if (pressed_in[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i]   = pressed_in[i];
          press_d[i]   = pressed_in[i];
          release_d[i] = ~pressed_in[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    any_d = |press_d;
  end

  // Debounce state and registered outputs; reset discards any pending count.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
    end
  end

  assign keys.key_level   = level_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;
  assign keys.any_press   = any_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4.
// Stimulus pushes the expected pulse events (absolute cycle, press, release);
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_key_conditioner;

  // KEY driven at the negedge where cyc==c is sampled at edge c+1;
  // level changes at that edge + 5, so it is visible at the negedge where cyc==c+6.
  localparam int LAT = 6;

  typedef struct {
    int         at;
    logic [2:0] press;
    logic [2:0] rel;
  } evt_t;

  logic clock;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  evt_t expQ[$];

  key_conditioner_if #(.NUM_KEYS(3)) bus ();

  key_conditioner #(
    .NUM_KEYS       (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (2)
  ) dut (
    .CLOCK_50(clock),
    .reset   (reset),
    .keys    (bus.slave)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Edge counter used as the time base for expected events.
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every DUT pulse against the front of the expected queue.
  always @(negedge clock) begin
    evt_t ev;
    if (expQ.size() > 0 && expQ[0].at <= cyc) begin
      ev = expQ.pop_front();
      total++;
      if (ev.at != cyc || bus.key_press !== ev.press || bus.key_release !== ev.rel ||
          bus.any_press !== (|ev.press)) begin
        bad++;
        $display("[TB] FAIL event: cyc=%0d press=%b rel=%b any=%b, required cyc=%0d press=%b rel=%b any=%b",
                 cyc, bus.key_press, bus.key_release, bus.any_press,
                 ev.at, ev.press, ev.rel, |ev.press);
      end
    end else if (bus.key_press !== 3'b000 || bus.key_release !== 3'b000 || bus.any_press !== 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_pulse: cyc=%0d press=%b rel=%b any=%b, required all zero",
               cyc, bus.key_press, bus.key_release, bus.any_press);
    end
  end

  task automatic applyStimulus(input logic [2:0] k);
    bus.KEY = k;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expectEvent(input int at, input logic [2:0] p, input logic [2:0] r);
    evt_t ev;
    ev.at    = at;
    ev.press = p;
    ev.rel   = r;
    expQ.push_back(ev);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expLevel);
    total++;
    if (bus.key_level !== expLevel) begin
      bad++;
      $display("[TB] FAIL %s: key_level=%b, required %b (cyc=%0d)", name, bus.key_level, expLevel, cyc);
    end
  endtask

  task automatic checkAllZero(input string name);
    total++;
    if ({bus.key_level, bus.key_press, bus.key_release, bus.any_press} !== 10'd0) begin
      bad++;
      $display("[TB] FAIL %s: level=%b press=%b rel=%b any=%b, required all zero",
               name, bus.key_level, bus.key_press, bus.key_release, bus.any_press);
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int c;
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b1;
    applyStimulus(3'b111);

    // 1: reset, then idle with all keys released.
    waitCycles(3);
    checkAllZero("reset_state");
    reset = 1'b0;
    waitCycles(20);
    checkOutput("idle_level", 3'b000);

    // 2: clean press of KEY[1], then release.
    c = cyc;
    applyStimulus(3'b101);
    expectEvent(c + LAT, 3'b010, 3'b000);
    waitCycles(LAT - 1);
    checkOutput("k1_before_accept", 3'b000);
    waitCycles(1);
    checkOutput("k1_accepted", 3'b010);
    c = cyc;
    applyStimulus(3'b111);
    expectEvent(c + LAT, 3'b000, 3'b010);
    waitCycles(8);
    checkOutput("k1_released", 3'b000);

    // 3: KEY[2] bounces 0,1,0,1 then holds 0; only the final edge is accepted.
    applyStimulus(3'b011);
    waitCycles(1);
    applyStimulus(3'b111);
    waitCycles(1);
    applyStimulus(3'b011);
    waitCycles(1);
    applyStimulus(3'b111);
    waitCycles(1);
    c = cyc;
    applyStimulus(3'b011);
    expectEvent(c + LAT, 3'b100, 3'b000);
    waitCycles(3);
    checkOutput("k2_during_bounce", 3'b000);
    waitCycles(2);
    checkOutput("k2_before_accept", 3'b000);
    waitCycles(1);
    checkOutput("k2_accepted", 3'b100);
    c = cyc;
    applyStimulus(3'b111);
    expectEvent(c + LAT, 3'b000, 3'b100);
    waitCycles(8);
    checkOutput("k2_released", 3'b000);

    // 4: hold KEY[0] for 10 cycles; level high for 10 cycles, shifted by latency.
    c = cyc;
    applyStimulus(3'b110);
    expectEvent(c + LAT, 3'b001, 3'b000);
    expectEvent(c + 10 + LAT, 3'b000, 3'b001);
    waitCycles(LAT);
    checkOutput("k0_held_first", 3'b001);
    waitCycles(4);
    applyStimulus(3'b111);
    waitCycles(LAT - 1);
    checkOutput("k0_held_last", 3'b001);
    waitCycles(1);
    checkOutput("k0_released", 3'b000);
    waitCycles(4);

    // 5: KEY[1] and KEY[2] pressed together, then released together.
    c = cyc;
    applyStimulus(3'b001);
    expectEvent(c + LAT, 3'b110, 3'b000);
    waitCycles(LAT);
    checkOutput("k12_accepted", 3'b110);
    c = cyc;
    applyStimulus(3'b111);
    expectEvent(c + LAT, 3'b000, 3'b110);
    waitCycles(8);
    checkOutput("k12_released", 3'b000);

    // 6: reset two cycles into a KEY[1] press; key held through reset release.
    applyStimulus(3'b101);
    waitCycles(2);
    reset = 1'b1;
    #1;
    checkAllZero("reset_async");
    waitCycles(3);
    checkAllZero("reset_held");
    c = cyc;
    reset = 1'b0;
    // First edge after release samples the held key; press shows five edges later.
    expectEvent(c + LAT, 3'b010, 3'b000);
    waitCycles(LAT - 1);
    checkOutput("k1_post_reset_pending", 3'b000);
    waitCycles(1);
    checkOutput("k1_post_reset_accepted", 3'b010);
    c = cyc;
    applyStimulus(3'b111);
    expectEvent(c + LAT, 3'b000, 3'b010);
    waitCycles(10);
    checkOutput("final_level", 3'b000);

    // Every expected event must have been consumed.
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL queue_drained: %0d events pending, required 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
